// File: rtl/cp0_timer_intc.sv
// CP0 count/compare timers and interrupt-pending unit with mask and priority encode.
// Optional macro CP0_TIMER_AUTO_RELOAD_EN makes CTRL.AUTO writable (periodic channel 0).
module cp0_timer_intc #(
    parameter int NUM_TIMERS  = 2,
    parameter int HW_INTR_NUM = 6,
    parameter int COUNT_W     = 32,
    parameter int PRESCALE_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_i,
    input  logic [4:0]             waddr_i,
    input  logic [31:0]            wdata_i,
    input  logic [4:0]             raddr_i,
    output logic [31:0]            rdata_o,
    input  logic [HW_INTR_NUM-1:0] intr_i,
    input  logic                   ie_i,
    input  logic                   exl_i,
    output logic                   intr_req_o,
    output logic [4:0]             intr_id_o,
    output logic [31:0]            pending_o,
    output logic [COUNT_W-1:0]     count_o
);

    localparam int TM_LO = 2 + HW_INTR_NUM;
    localparam logic [4:0] A_COUNT = 5'd0;
    localparam logic [4:0] A_CTRL  = 5'd1;
    localparam logic [4:0] A_MASK  = 5'd2;
    localparam logic [4:0] A_PEND  = 5'd3;
    localparam logic [4:0] A_CMP0  = 5'd4;
    localparam logic [4:0] A_SWSET = 5'd12;

    logic [COUNT_W-1:0]     count_q, count_d;
    logic [PRESCALE_W-1:0]  presc_q, presc_d;
    logic [PRESCALE_W-1:0]  div_q, div_d;
    logic                   ce_q, ce_d;
    logic [31:0]            mask_q, mask_d;
    logic [COUNT_W-1:0]     compare_q [NUM_TIMERS];
    logic [COUNT_W-1:0]     compare_d [NUM_TIMERS];
    logic [1:0]             sw_pend_q, sw_pend_d;
    logic [NUM_TIMERS-1:0]  tmr_pend_q, tmr_pend_d;
    logic [HW_INTR_NUM-1:0] sync1_q, sync2_q;
    logic                   req_q, req_d;
    logic [4:0]             id_q, id_d;
    logic                   auto_en;

`ifdef CP0_TIMER_AUTO_RELOAD_EN
    logic auto_q, auto_d;
    assign auto_en = auto_q;
`else
    assign auto_en = 1'b0;
`endif

    logic                  tick;
    logic [NUM_TIMERS-1:0] match;
    logic [NUM_TIMERS-1:0] wr_cmp;
    logic                  wr_count, wr_ctrl, wr_mask, wr_pend, wr_swset;
    logic [31:0]           pending, masked;

    assign wr_count = we_i && (waddr_i == A_COUNT);
    assign wr_ctrl  = we_i && (waddr_i == A_CTRL);
    assign wr_mask  = we_i && (waddr_i == A_MASK);
    assign wr_pend  = we_i && (waddr_i == A_PEND);
    assign wr_swset = we_i && (waddr_i == A_SWSET);

    always_comb begin
        tick = ce_q && (presc_q == div_q);
        for (int i = 0; i < NUM_TIMERS; i++) begin
            wr_cmp[i] = we_i && (waddr_i == A_CMP0 + 5'(i));
            match[i]  = tick && (count_q == compare_q[i]) && (compare_q[i] != '0);
        end
    end

    always_comb begin
        pending = '0;
        pending[1:0] = sw_pend_q;
        pending[2 +: HW_INTR_NUM] = sync2_q;
        pending[TM_LO +: NUM_TIMERS] = tmr_pend_q;
        masked = pending & mask_q;
    end

    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        ce_d      = ce_q;
        div_d     = div_q;
        mask_d    = mask_q;
        compare_d = compare_q;
        sw_pend_d = sw_pend_q;
        tmr_pend_d = tmr_pend_q;
        req_d     = ie_i && !exl_i && (|masked);
        id_d      = id_q;
`ifdef CP0_TIMER_AUTO_RELOAD_EN
        auto_d = auto_q;
        if (wr_ctrl) auto_d = wdata_i[1];
`endif

        if (wr_count || wr_ctrl) presc_d = '0;
        else if (ce_q) presc_d = tick ? '0 : presc_q + 1'b1;

        // An explicit COUNT write beats both reload and increment.
        if (wr_count) count_d = wdata_i[COUNT_W-1:0];
        else if (auto_en && match[0]) count_d = '0;
        else if (tick) count_d = count_q + 1'b1;

        if (wr_ctrl) begin
            ce_d  = wdata_i[0];
            div_d = wdata_i[8 +: PRESCALE_W];
        end
        if (wr_mask) mask_d = wdata_i;

        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (wr_cmp[i]) compare_d[i] = wdata_i[COUNT_W-1:0];
            tmr_pend_d[i] = match[i] |
                (tmr_pend_q[i] & ~(wr_cmp[i] | (wr_pend & wdata_i[TM_LO+i])));
        end

        sw_pend_d = (sw_pend_q & ~(wr_pend ? wdata_i[1:0] : 2'b00)) |
                    (wr_swset ? wdata_i[1:0] : 2'b00);

        for (int i = 31; i >= 0; i--) begin
            if (masked[i]) id_d = 5'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= '0;
            presc_q    <= '0;
            div_q      <= '0;
            ce_q       <= 1'b1;
            mask_q     <= '0;
            sw_pend_q  <= '0;
            tmr_pend_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            req_q      <= 1'b0;
            id_q       <= '0;
            for (int i = 0; i < NUM_TIMERS; i++) compare_q[i] <= '0;
`ifdef CP0_TIMER_AUTO_RELOAD_EN
            auto_q <= 1'b0;
`endif
        end else begin
            count_q    <= count_d;
            presc_q    <= presc_d;
            div_q      <= div_d;
            ce_q       <= ce_d;
            mask_q     <= mask_d;
            sw_pend_q  <= sw_pend_d;
            tmr_pend_q <= tmr_pend_d;
            sync1_q    <= intr_i;
            sync2_q    <= sync1_q;
            req_q      <= req_d;
            id_q       <= id_d;
            for (int i = 0; i < NUM_TIMERS; i++) compare_q[i] <= compare_d[i];
`ifdef CP0_TIMER_AUTO_RELOAD_EN
            auto_q <= auto_d;
`endif
        end
    end

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            A_COUNT: rdata_o[COUNT_W-1:0] = count_q;
            A_CTRL: begin
                rdata_o[0] = ce_q;
                rdata_o[1] = auto_en;
                rdata_o[8 +: PRESCALE_W] = div_q;
            end
            A_MASK:  rdata_o = mask_q;
            A_PEND:  rdata_o = pending;
            A_SWSET: rdata_o = pending;
            default: rdata_o = '0;
        endcase
        for (int i = 0; i < NUM_TIMERS; i++) begin
            if (raddr_i == A_CMP0 + 5'(i)) rdata_o[COUNT_W-1:0] = compare_q[i];
        end
    end

    assign intr_req_o = req_q;
    assign intr_id_o  = id_q;
    assign pending_o  = pending;
    assign count_o    = count_q;

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Bench for cp0_timer_intc: behavioural model feeds an expected queue, a negedge monitor compares.
// Covers CP0_TIMER_AUTO_RELOAD_EN when that macro is defined.
module tb_cp0_timer_intc;

    localparam int NT = 2;
    localparam int HW = 6;
    localparam int CW = 32;
    localparam int PW = 8;
    localparam int TM_LO = 2 + HW;
    localparam longint CMOD = longint'(1) << CW;
    localparam int W = 32 + 32 + 32 + 1 + 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          we;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic [4:0]    raddr;
    logic [31:0]   rdata;
    logic [HW-1:0] intr;
    logic          ie, exl;
    logic          intr_req;
    logic [4:0]    intr_id;
    logic [31:0]   pending;
    logic [CW-1:0] count;

    cp0_timer_intc #(.NUM_TIMERS(NT), .HW_INTR_NUM(HW), .COUNT_W(CW), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata), .intr_i(intr), .ie_i(ie), .exl_i(exl),
        .intr_req_o(intr_req), .intr_id_o(intr_id), .pending_o(pending), .count_o(count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint        m_count, m_presc, m_div;
    longint        m_cmp [NT];
    bit            m_ce, m_auto, m_req;
    int            m_id;
    logic [31:0]   m_mask;
    logic [1:0]    m_sw;
    logic [NT-1:0] m_tp;
    logic [HW-1:0] m_hw1, m_hw2;

    logic [W-1:0] exp_q[$];
    int n_total = 0;
    int n_bad = 0;

    task automatic m_reset();
        m_count = 0; m_presc = 0; m_div = 0; m_ce = 1; m_auto = 0;
        m_req = 0; m_id = 0; m_mask = 0; m_sw = 0; m_tp = 0; m_hw1 = 0; m_hw2 = 0;
        for (int i = 0; i < NT; i++) m_cmp[i] = 0;
    endtask

    function automatic logic [31:0] m_pend();
        logic [31:0] p = 0;
        p[1:0] = m_sw;
        for (int i = 0; i < HW; i++) p[2+i] = m_hw2[i];
        for (int i = 0; i < NT; i++) p[TM_LO+i] = m_tp[i];
        return p;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] r = 0;
        if (a == 0) r = 32'(m_count);
        else if (a == 1) r = 32'(m_ce) | (32'(m_auto) << 1) | (32'(m_div) << 8);
        else if (a == 2) r = m_mask;
        else if (a == 3 || a == 12) r = m_pend();
        else if (a >= 4 && a < 4 + NT) r = 32'(m_cmp[a-4]);
        return r;
    endfunction

    task automatic m_step();
        logic [31:0] mp;
        bit tick;
        bit mt [NT];
        mp = m_pend() & m_mask;
        m_req = ie && !exl && (mp != 0);
        for (int i = 31; i >= 0; i--) if (mp[i]) m_id = i;
        tick = m_ce && (m_presc == m_div);
        for (int i = 0; i < NT; i++) mt[i] = tick && (m_count == m_cmp[i]) && (m_cmp[i] != 0);

        if (we && (waddr == 0 || waddr == 1)) m_presc = 0;
        else if (m_ce) m_presc = tick ? 0 : (m_presc + 1) % 256;

        if (we && waddr == 0) m_count = longint'(wdata) % CMOD;
        else if (m_auto && mt[0]) m_count = 0;
        else if (tick) m_count = (m_count + 1) % CMOD;

        if (we && waddr == 1) begin
            m_ce = wdata[0];
            m_div = longint'(wdata[15:8]);
`ifdef CP0_TIMER_AUTO_RELOAD_EN
            m_auto = wdata[1];
`endif
        end
        if (we && waddr == 2) m_mask = wdata;
        for (int i = 0; i < NT; i++) begin
            if (we && waddr == 5'(4 + i)) begin
                m_cmp[i] = longint'(wdata) % CMOD;
                m_tp[i] = 0;
            end
            if (we && waddr == 3 && wdata[TM_LO+i]) m_tp[i] = 0;
            if (mt[i]) m_tp[i] = 1;
        end
        if (we && waddr == 3) m_sw = m_sw & ~wdata[1:0];
        if (we && waddr == 12) m_sw = m_sw | wdata[1:0];
        m_hw2 = m_hw1;
        m_hw1 = intr;
    endtask

    always @(posedge clk) begin
        if (rst) m_reset();
        else m_step();
        #2;
        if (rst) m_reset();
        exp_q.push_back({m_read(raddr), 32'(m_count), m_pend(), m_req, 5'(m_id)});
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rdata",    rdata,          e[W-1 -: 32]);
            chk("count",    32'(count),     e[69:38]);
            chk("pending",  pending,        e[37:6]);
            chk("intr_req", 32'(intr_req),  32'(e[5]));
            chk("intr_id",  32'(intr_id),   32'(e[4:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1; waddr = a; wdata = d;
        cyc(1);
        we = 0;
    endtask

    task automatic wait_model_count(input longint target);
        int budget = 200;
        while (m_count != target && budget > 0) begin
            cyc(1);
            budget--;
        end
        if (budget == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL wait_count: got %0d expected %0d", m_count, target);
        end
    endtask

    initial begin
        longint tgt;
        logic [31:0] r;
        rst = 1; we = 0; waddr = 0; wdata = 0; raddr = 1; intr = 0; ie = 0; exl = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        cyc(12);

        // compare channel 0 with mask on its pending bit
        ie = 1; exl = 0; raddr = 3;
        wr(2, 32'h1 << TM_LO);
        wr(0, 0);
        wr(4, 10);
        cyc(15);
        wr(4, 0);
        cyc(3);

        // prescaler and wrap
        raddr = 0;
        wr(1, (3 << 8) | 1);
        cyc(20);
        wr(0, 32'hFFFF_FFFF);
        cyc(12);
        wr(1, 1);
        wr(0, 32'hFFFF_FFFD);
        cyc(6);

        // hardware line pulse, then the same with EXL set
        wr(2, 32'h4);
        raddr = 3;
        intr = 6'h01; cyc(5); intr = 0; cyc(4);
        exl = 1;
        intr = 6'h01; cyc(5); intr = 0; cyc(4);
        exl = 0;

        // software bits, then simultaneous match and W1C on timer 1
        wr(2, 32'hFFFF_FFFF);
        wr(12, 32'h3);
        wr(3, 32'h1);
        cyc(2);
        tgt = (m_count + 6) % CMOD;
        wr(5, 32'(tgt));
        wait_model_count(tgt);
        wr(3, 32'h1 << (TM_LO + 1));
        cyc(4);
        wr(3, 32'hFFFF_FFFF);
        cyc(2);

`ifdef CP0_TIMER_AUTO_RELOAD_EN
        wr(2, 32'h1 << TM_LO);
        raddr = 1;
        wr(0, 0);
        wr(4, 4);
        wr(1, 32'h3);
        cyc(22);
        wr(1, 32'h1);
`endif

        // mid-count reset
        wr(4, 32'(m_count + 3));
        rst = 1; cyc(2); rst = 0;
        cyc(6);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            ie = $urandom_range(0, 3) != 0;
            exl = $urandom_range(0, 7) == 0;
            intr = HW'($urandom);
            raddr = 5'($urandom_range(0, 15));
            we = $urandom_range(0, 2) == 0;
            waddr = 5'($urandom_range(0, 13));
            r = $urandom;
            case (waddr)
                0: wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                       : 32'($urandom_range(0, 40));
                1: wdata = (r & 32'hFFFF_00FE) | (32'($urandom_range(0, 3)) << 8) |
                           32'($urandom_range(0, 7) != 0);
                4, 5: wdata = ($urandom_range(0, 7) == 0) ? 32'h0
                                                          : 32'((m_count + $urandom_range(0, 30)) % CMOD);
                default: wdata = r;
            endcase
            if ($urandom_range(0, 299) == 0) begin
                we = 0;
                rst = 1;
            end
            cyc(1);
            rst = 0;
        end
        we = 0;
        cyc(3);

        @(negedge clk);
        #1;
        n_total++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
